// File: rtl/rel_phase_sched.sv
// rel_phase_sched: credit-gated frame scheduler issuing aligned 4-step pixel quads; define REL_PHASE_SCHED_STATS_EN for stall/quad counters
module rel_phase_sched #(
  parameter int CREDITS = 32,
  parameter int DIM_W   = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DIM_W-1:0] cfg_width_i,
  input  logic [DIM_W-1:0] cfg_height_i,
  input  logic [3:0]       pix_vld_i,
  input  logic [31:0]      pix_data_i,
  output logic [3:0]       pix_rdy_o,
  output logic             core_vld_o,
  output logic [31:0]      core_pixel_o,
  output logic             core_last_o,
  input  logic             out_pop_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             credit_err_o
`ifdef REL_PHASE_SCHED_STATS_EN
  ,
  output logic [31:0]      stall_credit_o,
  output logic [31:0]      stall_input_o,
  output logic [31:0]      quad_cnt_o
`endif
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [DIM_W-1:0] w_q, h_q, col, row;
  logic [CW-1:0] credits;
  logic all_vld, fire, col_end, frame_end, accept;
  assign all_vld   = &pix_vld_i;
  assign fire      = (state == RUN) && (credits != '0) && all_vld;
  assign col_end   = col == w_q - DIM_W'(1);
  assign frame_end = col_end && (row == h_q - DIM_W'(1));
  assign accept    = (state == IDLE) && start_i;
  assign pix_rdy_o = {4{fire}};
  assign busy_o    = state != IDLE;
  assign done_o    = state == DONE;
  // next-state: zero-sized frames skip straight to DONE, abort or final quad enters DRAIN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !start_i ? IDLE : (cfg_width_i == '0 || cfg_height_i == '0) ? DONE : RUN;
      RUN:     state_nxt = (abort_i || (fire && frame_end)) ? DRAIN : RUN;
      DRAIN:   state_nxt = (credits == CMAX) ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // state, latched frame geometry and row/column position
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      w_q   <= '0;
      h_q   <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        w_q <= cfg_width_i;
        h_q <= cfg_height_i;
      end
      if (state == DONE) begin
        col <= '0;
        row <= '0;
      end else if (fire) begin
        col <= col_end ? '0 : col + DIM_W'(1);
        row <= col_end ? row + DIM_W'(1) : row;
      end
    end
  // one-cycle registered issue to the phase core; pixel holds between quads
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      core_vld_o   <= 1'b0;
      core_last_o  <= 1'b0;
      core_pixel_o <= '0;
    end else begin
      core_vld_o  <= fire;
      core_last_o <= fire && col_end;
      if (fire) core_pixel_o <= pix_data_i;
    end
  // credits mirror free result-FIFO slots; a pop with nothing in flight is flagged, not counted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      credits      <= CMAX;
      credit_err_o <= 1'b0;
    end else begin
      if (fire && !out_pop_i) credits <= credits - CW'(1);
      else if (!fire && out_pop_i && credits != CMAX) credits <= credits + CW'(1);
      if (!fire && out_pop_i && credits == CMAX) credit_err_o <= 1'b1;
    end
  // sticky abort status, cleared by the next accepted start
  always_ff @(posedge clk or posedge rst)
    if (rst) aborted_o <= 1'b0;
    else if (accept) aborted_o <= 1'b0;
    else if (state == RUN && abort_i) aborted_o <= 1'b1;
`ifdef REL_PHASE_SCHED_STATS_EN
  // saturating run statistics, cleared on accepted start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_credit_o <= '0;
      stall_input_o  <= '0;
      quad_cnt_o     <= '0;
    end else if (accept) begin
      stall_credit_o <= '0;
      stall_input_o  <= '0;
      quad_cnt_o     <= '0;
    end else if (state == RUN) begin
      if (all_vld && credits == '0 && stall_credit_o != '1) stall_credit_o <= stall_credit_o + 32'd1;
      if (!all_vld && stall_input_o != '1) stall_input_o <= stall_input_o + 32'd1;
      if (fire && quad_cnt_o != '1) quad_cnt_o <= quad_cnt_o + 32'd1;
    end
`endif
endmodule
